// File: rtl/alu16_sequencer_pkg.sv
// Shared definitions for the 16-bit ALU sequencer: op codes, ALU opcodes,
// FSM states and flag bit positions.
package alu16_sequencer_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned FLAG_W   = 4;
  localparam int unsigned OP_W     = 2;
  localparam int unsigned ALU_OP_W = 3;

  // 16-bit operations handled by the sequencer
  typedef enum logic [OP_W-1:0] {
    OP_ADD16     = 2'b00,
    OP_ADD_SP_E8 = 2'b01,
    OP_INC16     = 2'b10,
    OP_DEC16     = 2'b11
  } op_e;

  // 8-bit ALU opcodes (instruction bits [5:3] encoding)
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_ADC = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_SBC = 3'b011;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Flag vector layout {Z,N,H,C}
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_H = 1;
  localparam int unsigned FLAG_C = 0;

  // True for the 16-bit increment/decrement ops
  function automatic logic is_inc_dec(op_e op);
    return (op == OP_INC16) || (op == OP_DEC16);
  endfunction

endpackage

// File: rtl/alu16_sequencer.sv
// Two-pass sequencer running 16-bit adds/inc/dec through the shared 8-bit ALU.
// Optional feature macro: ALU16_INC_DEC_EN (when undefined, INC16/DEC16 pass
// i_X and i_F straight through without touching the ALU).
module alu16_sequencer
  import alu16_sequencer_pkg::*;
(
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_Start,
  input  logic [OP_W-1:0]     i_Op,
  input  logic [WORD_W-1:0]   i_X,
  input  logic [WORD_W-1:0]   i_Y,
  input  logic [FLAG_W-1:0]   i_F,
  output logic                o_Busy,
  output logic                o_Done,
  output logic [WORD_W-1:0]   o_Result,
  output logic [FLAG_W-1:0]   o_F,
  output logic [BYTE_W-1:0]   o_Alu_A,
  output logic [BYTE_W-1:0]   o_Alu_B,
  output logic [ALU_OP_W-1:0] o_Alu_Opcode,
  output logic [FLAG_W-1:0]   o_Alu_F,
  input  logic [BYTE_W-1:0]   i_Alu_Result,
  input  logic [FLAG_W-1:0]   i_Alu_F
);

`ifdef ALU16_INC_DEC_EN
  localparam logic INC_DEC_EN = 1'b1;
`else
  localparam logic INC_DEC_EN = 1'b0;
`endif

  // An op uses the ALU unless it is INC/DEC with the feature compiled out
  function automatic logic alu_used(op_e op);
    return INC_DEC_EN || !is_inc_dec(op);
  endfunction

  state_e              state_q, state_d;
  op_e                 op_q, op_next;
  logic [WORD_W-1:0]   x_q, y_q;
  logic [FLAG_W-1:0]   f_q;
  logic [BYTE_W-1:0]   lo_q;
  logic                lo_h_q, lo_c_q;
  logic                accept;
  logic                busy_d;
  logic [WORD_W-1:0]   res_new;
  logic [FLAG_W-1:0]   f_new;
  logic                unused_alu_flags;

  assign unused_alu_flags = ^{i_Alu_F[FLAG_Z], i_Alu_F[FLAG_N]};

  // State register
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, accept decode and ALU input drive
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    o_Alu_A      = '0;
    o_Alu_B      = '0;
    o_Alu_Opcode = ALU_ADD;
    o_Alu_F      = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          accept  = 1'b1;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        state_d = ST_HIGH;
        if (alu_used(op_q)) begin
          o_Alu_A = x_q[7:0];
          case (op_q)
            OP_ADD16:     o_Alu_B = y_q[7:0];
            OP_ADD_SP_E8: o_Alu_B = y_q[7:0];
            default:      o_Alu_B = 8'h01;
          endcase
          o_Alu_Opcode = (op_q == OP_DEC16) ? ALU_SUB : ALU_ADD;
        end
      end
      ST_HIGH: begin
        state_d = ST_DONE;
        if (alu_used(op_q)) begin
          o_Alu_A = x_q[15:8];
          case (op_q)
            OP_ADD16:     o_Alu_B = y_q[15:8];
            OP_ADD_SP_E8: o_Alu_B = {BYTE_W{y_q[7]}};
            default:      o_Alu_B = 8'h00;
          endcase
          o_Alu_Opcode     = (op_q == OP_DEC16) ? ALU_SBC : ALU_ADC;
          o_Alu_F[FLAG_C]  = lo_c_q;
        end
      end
      ST_DONE: begin
        if (i_Start) begin
          accept  = 1'b1;
          state_d = ST_LOW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    op_next = accept ? op_e'(i_Op) : op_q;
    busy_d  = ((state_d == ST_LOW) || (state_d == ST_HIGH)) && alu_used(op_next);
  end

  // Final result and flags assembled at the end of the high pass
  always_comb begin
    f_new = '0;
    case (op_q)
      OP_ADD16: begin
        f_new[FLAG_Z] = f_q[FLAG_Z];
        f_new[FLAG_H] = i_Alu_F[FLAG_H];
        f_new[FLAG_C] = i_Alu_F[FLAG_C];
      end
      OP_ADD_SP_E8: begin
        f_new[FLAG_H] = lo_h_q;
        f_new[FLAG_C] = lo_c_q;
      end
      default: f_new = f_q;
    endcase
    res_new = alu_used(op_q) ? {i_Alu_Result, lo_q} : x_q;
  end

  // Operand latch, low-pass capture, result/flag and status registers
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      op_q     <= OP_ADD16;
      x_q      <= '0;
      y_q      <= '0;
      f_q      <= '0;
      lo_q     <= '0;
      lo_h_q   <= 1'b0;
      lo_c_q   <= 1'b0;
      o_Result <= '0;
      o_F      <= '0;
      o_Busy   <= 1'b0;
      o_Done   <= 1'b0;
    end else begin
      o_Busy <= busy_d;
      o_Done <= (state_d == ST_DONE);
      if (accept) begin
        op_q <= op_e'(i_Op);
        x_q  <= i_X;
        y_q  <= i_Y;
        f_q  <= i_F;
      end
      if (state_q == ST_LOW) begin
        lo_q   <= i_Alu_Result;
        lo_h_q <= i_Alu_F[FLAG_H];
        lo_c_q <= i_Alu_F[FLAG_C];
      end
      if (state_q == ST_HIGH) begin
        o_Result <= res_new;
        o_F      <= f_new;
      end
    end
  end

endmodule

// File: tb/tb_alu16_sequencer.sv
// Scoreboard bench for alu16_sequencer with a behavioural 8-bit ALU beside it.
// Honours ALU16_INC_DEC_EN the same way as the design.
module tb_alu16_sequencer;

`ifdef ALU16_INC_DEC_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic        i_Start;
  logic [1:0]  i_Op;
  logic [15:0] i_X, i_Y;
  logic [3:0]  i_F;
  logic        o_Busy, o_Done;
  logic [15:0] o_Result;
  logic [3:0]  o_F;
  logic [7:0]  o_Alu_A, o_Alu_B;
  logic [2:0]  o_Alu_Opcode;
  logic [3:0]  o_Alu_F;
  logic [7:0]  alu_res;
  logic [3:0]  alu_f;

  alu16_sequencer dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_Op(i_Op),
    .i_X(i_X), .i_Y(i_Y), .i_F(i_F), .o_Busy(o_Busy), .o_Done(o_Done),
    .o_Result(o_Result), .o_F(o_F), .o_Alu_A(o_Alu_A), .o_Alu_B(o_Alu_B),
    .o_Alu_Opcode(o_Alu_Opcode), .o_Alu_F(o_Alu_F),
    .i_Alu_Result(alu_res), .i_Alu_F(alu_f)
  );

  always #5 i_Clk = ~i_Clk;

  // Behavioural 8-bit ALU: ADD/ADC/SUB/SBC with {Z,N,H,C} out
  logic [8:0] full;
  logic [4:0] half;
  logic       sub, cin;
  always_comb begin
    sub = o_Alu_Opcode[1];
    cin = o_Alu_Opcode[0] ? o_Alu_F[0] : 1'b0;
    if (!sub) begin
      full = {1'b0, o_Alu_A} + {1'b0, o_Alu_B} + 9'(cin);
      half = {1'b0, o_Alu_A[3:0]} + {1'b0, o_Alu_B[3:0]} + 5'(cin);
    end else begin
      full = {1'b0, o_Alu_A} - {1'b0, o_Alu_B} - 9'(cin);
      half = {1'b0, o_Alu_A[3:0]} - {1'b0, o_Alu_B[3:0]} - 5'(cin);
    end
    alu_res = full[7:0];
    alu_f   = {(full[7:0] == 8'h00), sub, half[4], full[8]};
  end

  typedef struct {
    logic [15:0] res;
    logic [3:0]  f;
    int          done_cyc;
    int          busy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: whole 16-bit arithmetic on the operands
  task automatic ref_model(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                           input logic [3:0] f, output logic [15:0] res, output logic [3:0] fo);
    int  sum, e;
    bit  h, c;
    case (op)
      2'd0: begin
        sum = int'(x) + int'(y);
        res = sum[15:0];
        h   = (int'(x & 16'h0FFF) + int'(y & 16'h0FFF)) > 32'h0FFF;
        c   = sum > 32'hFFFF;
        fo  = {f[3], 1'b0, h, c};
      end
      2'd1: begin
        e   = int'(y[7:0]);
        sum = int'(x) + ((e >= 128) ? e - 256 : e);
        res = sum[15:0];
        h   = (int'(x[3:0]) + (e & 15)) > 15;
        c   = (int'(x[7:0]) + e) > 255;
        fo  = {2'b00, h, c};
      end
      2'd2: begin res = EN ? x + 16'd1 : x; fo = f; end
      default: begin res = EN ? x - 16'd1 : x; fo = f; end
    endcase
  endtask

  // Issue one op at a negedge while the DUT is in IDLE or DONE; returns at the DONE-cycle negedge
  task automatic issue(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                       input logic [3:0] f);
    exp_t e;
    i_Op = op; i_X = x; i_Y = y; i_F = f; i_Start = 1'b1;
    ref_model(op, x, y, f, e.res, e.f);
    e.done_cyc = cyc + 3;
    e.busy     = (op[1] && !EN) ? 0 : 2;
    q.push_back(e);
    @(posedge i_Clk);
    repeat (2) begin
      @(negedge i_Clk);
      i_Start = 1'b1;
      i_Op = 2'($urandom); i_X = 16'($urandom); i_Y = 16'($urandom); i_F = 4'($urandom);
    end
    @(negedge i_Clk);
    i_Start = 1'b0;
    i_Op = op; i_X = x; i_Y = y; i_F = f;
  endtask

  task automatic idle(input int n);
    i_Start = 1'b0;
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   32'(o_Busy), 0);
    check({tag, "_done"},   32'(o_Done), 0);
    check({tag, "_result"}, 32'(o_Result), 0);
    check({tag, "_flags"},  32'(o_F), 0);
    check({tag, "_alu_in"}, {o_Alu_A, o_Alu_B, 5'(o_Alu_Opcode), 4'(o_Alu_F)}, 0);
  endtask

  // Monitor: pops the scoreboard whenever o_Done is seen
  initial begin
    exp_t e;
    forever begin
      @(posedge i_Clk);
      #1;
      cyc++;
      if (i_Reset) begin
        busy_cnt = 0;
      end else begin
        if (o_Busy) busy_cnt++;
        if (o_Done) begin
          if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            check("result",  32'(o_Result), 32'(e.res));
            check("flags",   32'(o_F), 32'(e.f));
            check("latency", cyc, e.done_cyc);
            check("busy_cycles", busy_cnt, e.busy);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // Stimulus
  initial begin
    i_Reset = 1'b1; i_Start = 1'b0; i_Op = '0; i_X = '0; i_Y = '0; i_F = '0;
    repeat (2) @(posedge i_Clk);
    #1;
    check_all_zero("reset");
    @(negedge i_Clk);
    i_Reset = 1'b0;

    // Directed cases
    issue(2'd0, 16'h0FFF, 16'h0001, 4'h8);
    idle(1);
    issue(2'd0, 16'hFFFF, 16'h0001, 4'h0);
    issue(2'd1, 16'h00FF, 16'h0001, 4'hF);
    issue(2'd1, 16'h0000, 16'h00FF, 4'h0);
    idle(2);

    // Back-to-back with start held high
    repeat (4) issue(2'd0, 16'h1234, 16'h1111, 4'h0);
    idle(1);

    // Reset during the high pass
    i_Op = 2'd0; i_X = 16'h1111; i_Y = 16'h2222; i_F = 4'h0; i_Start = 1'b1;
    @(posedge i_Clk);
    @(negedge i_Clk); i_Start = 1'b0;
    @(negedge i_Clk); i_Reset = 1'b1;
    @(posedge i_Clk);
    #1;
    check_all_zero("midop_reset");
    @(negedge i_Clk);
    i_Reset = 1'b0;
    idle(1);
    issue(2'd0, 16'h0101, 16'h0202, 4'h0);

    // INC/DEC
    issue(2'd3, 16'h1000, 16'h0000, 4'h5);
    issue(2'd2, 16'hFFFF, 16'h0000, 4'hA);
    issue(2'd3, 16'h0000, 16'h0000, 4'h3);
    idle(1);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    // Drain with a bounded wait
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge i_Clk);
    while (q.size() != 0) begin
      void'(q.pop_front());
      check("drain_timeout", 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu16_sequencer.md
Name: alu16_sequencer

Overview:
Multi-cycle controller that sequences the 8-bit main ALU over two passes to execute 16-bit ops: ADD HL,rr and ADD SP,e8 / LD HL,SP+e8. Pass 1 handles the low byte and pass 2 the high byte; the carry between passes is chained through the ALU's flag input. The block sits beside the CPU register file. While it is busy, it owns the ALU input mux and drives the ALU's A, B, opcode and flag inputs; otherwise the main datapath owns them.

Parameters:
None. All widths are fixed by the 8-bit ALU.

Ports:
i_Clk  in  1  system clock, rising edge
i_Reset  in  1  synchronous, active-high reset
i_Start  in  1  request pulse; sampled only in IDLE or DONE
i_Op  in  2  00 ADD16, 01 ADD_SP_E8, 10 INC16, 11 DEC16
i_X  in  16  first operand (HL or SP)
i_Y  in  16  second operand (rr); for ADD_SP_E8 only [7:0] is used, as signed e8
i_F  in  4  current flags {Z,N,H,C}
o_Busy  out  1  high in LOW and HIGH states; selects this block on the ALU input mux
o_Done  out  1  one-cycle pulse; o_Result and o_F are valid
o_Result  out  16  registered 16-bit result, held until the next accept or reset
o_F  out  4  registered new flags, held with o_Result
o_Alu_A  out  8  ALU accumulator input
o_Alu_B  out  8  ALU second input
o_Alu_Opcode  out  3  ALU op (bits [5:3] encoding)
o_Alu_F  out  4  ALU old-flag input
i_Alu_Result  in  8  ALU result
i_Alu_F  in  4  ALU new flags {Z,N,H,C}

Behaviour:
- Clock and reset: one clock, i_Clk. i_Reset is synchronous and active-high.
- FSM states: IDLE -> LOW -> HIGH -> DONE -> IDLE.
- Accept: in DONE, i_Start=1 goes to LOW, giving back-to-back ops every 3 cycles.
  - On accept, latch i_Op, i_X, i_Y and i_F.
  - i_Start is ignored in LOW and HIGH.
- Latency: accept at edge N gives LOW in cycle N+1, HIGH in N+2, and o_Done=1 in N+3.
- ALU drive: combinational from the state and latched operands.
  - Outside LOW/HIGH, all o_Alu_* outputs are 0.
- LOW state:
  - A = X[7:0].
  - ADD16: B = Y[7:0], opcode ADD (000).
  - ADD_SP_E8: B = e8, opcode ADD (000).
  - INC16: B = 0x01, opcode ADD (000).
  - DEC16: B = 0x01, opcode SUB (010).
  - o_Alu_F = 0.
  - At the LOW->HIGH edge, register i_Alu_Result into the low-byte result, and register the low H and C flags.
- HIGH state:
  - A = X[15:8].
  - ADD16: B = Y[15:8], opcode ADC (001).
  - ADD_SP_E8: B = {8{e8[7]}}, opcode ADC (001).
  - INC16: B = 0x00, opcode ADC (001).
  - DEC16: B = 0x00, opcode SBC (011).
  - o_Alu_F = {3'b0, low C}. For SBC, the ALU's C flag is the borrow, so it feeds through unchanged.
  - At the HIGH->DONE edge, register the high-byte result and the high H and C flags.
- Flags, written to o_F at the HIGH->DONE edge:
  - ADD16: {Z=old Z, N=0, H=high H, C=high C}.
  - ADD_SP_E8: {0, 0, low H, low C}, computed as an unsigned low-byte add.
  - INC16/DEC16: o_F = latched i_F (unchanged).
- Reset, including mid-operation: state = IDLE; o_Busy, o_Done, o_Result and o_F = 0; no o_Done pulse for the aborted op.
- Wrap-around: 16-bit results wrap modulo 2^16 (for example 0xFFFF+1 = 0x0000).

Optional Feature:
Macro: ALU16_INC_DEC_EN.
- Defined: INC16/DEC16 execute as described in Behaviour.
- Undefined: ops 10/11 are still accepted with the same 3-cycle timing, but:
  - o_Busy stays 0 and the ALU is not driven;
  - o_Result = i_X and o_F = i_F.

Decomposition:
- Shared package holds:
  - op codes OP_ADD16, OP_ADD_SP_E8, OP_INC16, OP_DEC16;
  - ALU opcode constants ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC;
  - FSM state encodings;
  - flag bit indices FLAG_Z, FLAG_N, FLAG_H, FLAG_C.
- No sub-module. The ALU stays a single external instance shared with the datapath through o_Busy.

Test Plan:
1. ADD16: X=0x0FFF, Y=0x0001, i_F=0x8 -> o_Result=0x1000, o_F=0xA. o_Done arrives exactly 3 cycles after accept; o_Busy is high for 2 cycles.
2. ADD16: X=0xFFFF, Y=0x0001, i_F=0x0 -> o_Result=0x0000, o_F=0x3 (Z is not set by the 16-bit op).
3. ADD_SP_E8:
   - X=0x00FF, e8=0x01 -> 0x0100, o_F=0x3.
   - X=0x0000, e8=0xFF -> 0xFFFF, o_F=0x0.
4. i_Start held high continuously with ADD16 0x1234+0x1111 -> o_Result=0x2345 every 3 cycles. Pulses asserted during LOW/HIGH produce no extra ops.
5. Reset asserted in HIGH state -> next cycle all outputs are 0, state is IDLE, and no o_Done. A following start completes normally.
6. DEC16: X=0x1000, i_F=0x5:
   - With ALU16_INC_DEC_EN: o_Result=0x0FFF, o_F=0x5.
   - Without the macro: o_Result=0x1000, o_F=0x5, and o_Busy stays 0.
